// File: rtl/mips_dmem_responder.sv
// ---------------------------------------------------------------------------
// mips_dmem_responder
//
// Target end of the MIPS core's data-memory load/store interface. Accepts one
// load or store at a time, waits WAIT_CYCLES extra cycles, performs the access
// against internal word storage and returns read data (or store completion)
// with an error flag. There is no pipelining: a new request is only accepted
// after the previous response has been consumed.
//
// Optional feature macro: MIPS_DMEM_BYTE_STROBE_EN
//   defined     -> extra input req_be[3:0]; stores write only enabled bytes,
//                  req_be == 0 store is a legal no-op, loads ignore req_be.
//   not defined -> every store writes the full 32-bit word.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_valid,
// rsp_rdata and rsp_err are held stable until that edge. Neither ready signal
// depends combinationally on the opposite valid.
//
// Ports
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       asynchronous reset, active-low
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request (registered)
//   req_write  in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      store data
//   req_be     in   4       byte enables (only with MIPS_DMEM_BYTE_STROBE_EN)
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       requester consumes response
//   rsp_rdata  out  32      load data (0 for stores and errors)
//   rsp_err    out  1       misaligned or out-of-range access
//   dbg_state  out  2       current FSM state (0 IDLE, 1 WAIT, 2 ACCESS, 3 RESP)
// ---------------------------------------------------------------------------
module mips_dmem_responder #(
    parameter int DATA_MEM_DEPTH = 1024,
    parameter int ADDR_W         = 10,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
`ifdef MIPS_DMEM_BYTE_STROBE_EN
    input  logic [3:0]        req_be,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = (DATA_MEM_DEPTH > 1) ? $clog2(DATA_MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_be;
    logic [31:0]       mem [DATA_MEM_DEPTH];
    logic              access_err;
    logic [IDX_W-1:0]  word_idx;
    logic              req_fire;

    assign dbg_state = state;
    assign req_fire  = req_valid && req_ready;

    // Error check works on the captured address so the requester may change
    // its inputs freely once the request has been accepted.
    always_comb begin
        access_err = (cap_addr[1:0] != 2'b00) ||
                     (32'(cap_addr[ADDR_W-1:2]) >= 32'(DATA_MEM_DEPTH));
        word_idx   = IDX_W'(cap_addr[ADDR_W-1:2]);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_fire) state_next = ST_WAIT;
            ST_WAIT:   if (wait_cnt == 4'd0) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // req_ready is registered from the next state, so it rises one edge after
    // reset release and one edge after the response handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < DATA_MEM_DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
`ifdef MIPS_DMEM_BYTE_STROBE_EN
                        cap_be    <= req_be;
`else
                        cap_be    <= 4'hF;
`endif
                        wait_cnt  <= 4'(WAIT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= access_err;
                    rsp_rdata <= (!cap_write && !access_err) ? mem[word_idx] : 32'd0;
                    if (cap_write && !access_err) begin
                        for (int b = 0; b < 4; b++) begin
                            if (cap_be[b]) begin
                                mem[word_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_mips_dmem_responder
//
// Two responders share clock and reset:
//   index 0: WAIT_CYCLES = 2, DATA_MEM_DEPTH = 128
//   index 1: WAIT_CYCLES = 0, DATA_MEM_DEPTH = 1024
// A per-instance monitor predicts, from the accepted request stream, when the
// response must appear and what it must carry (word-array memory model,
// alignment/range error rule, fixed latency of WAIT_CYCLES+2 edges), and
// compares the outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [9:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;
    logic [1:0]  dbg_state [2];

    int checks = 0;
    int errors = 0;
    logic seen_edge;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) seen_edge <= 1'b0;
        else      seen_edge <= 1'b1;
    end

    // ---------------- DUTs ----------------
    mips_dmem_responder #(.DATA_MEM_DEPTH(128), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef MIPS_DMEM_BYTE_STROBE_EN
        .req_be(req_be[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
    );

    mips_dmem_responder #(.DATA_MEM_DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef MIPS_DMEM_BYTE_STROBE_EN
        .req_be(req_be[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // ---------------- behavioural monitors ----------------
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int WC  = (g == 0) ? 2 : 0;
        localparam int DEP = (g == 0) ? 128 : 1024;
        logic [32:0] exp_q[$];
        logic [31:0] model_mem [256];
        bit          busy;
        int          k;

        always @(negedge clk) begin
            logic [9:0]  a;
            logic        e;
            logic [31:0] rd;
            if (!rst) begin
                busy = 1'b0;
                k    = 0;
                exp_q.delete();
                for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
                check($sformatf("d%0d_rst_rsp_valid", g), 32'(rsp_valid[g]), 32'd0);
                check($sformatf("d%0d_rst_req_ready", g), 32'(req_ready[g]), 32'd0);
            end else if (!busy) begin
                check($sformatf("d%0d_idle_rsp_valid", g), 32'(rsp_valid[g]), 32'd0);
                check($sformatf("d%0d_idle_req_ready", g), 32'(req_ready[g]), 32'(seen_edge));
                if (req_valid[g] && req_ready[g]) begin
                    a  = req_addr[g];
                    e  = (a % 4 != 0) || (int'(a / 4) >= DEP);
                    rd = 32'd0;
                    if (!e) begin
                        if (req_write[g]) begin
                            for (int b = 0; b < 4; b++) begin
`ifdef MIPS_DMEM_BYTE_STROBE_EN
                                if (req_be[g][b])
`endif
                                model_mem[a / 4][8*b +: 8] = req_wdata[g][8*b +: 8];
                            end
                        end else begin
                            rd = model_mem[a / 4];
                        end
                    end
                    exp_q.push_back({e, rd});
                    busy = 1'b1;
                    k    = 0;
                end
            end else begin
                k++;
                check($sformatf("d%0d_busy_req_ready", g), 32'(req_ready[g]), 32'd0);
                if (k < WC + 3) begin
                    check($sformatf("d%0d_early_rsp_valid", g), 32'(rsp_valid[g]), 32'd0);
                end else begin
                    check($sformatf("d%0d_rsp_valid", g), 32'(rsp_valid[g]), 32'd1);
                    check($sformatf("d%0d_rsp_rdata", g), rsp_rdata[g], exp_q[0][31:0]);
                    check($sformatf("d%0d_rsp_err", g), 32'(rsp_err[g]), 32'(exp_q[0][32]));
                    if (rsp_ready[g]) begin
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send_req(input int d, input bit wr, input logic [9:0] a,
                            input logic [31:0] wd, input logic [3:0] be, output bit ok);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            timeout_fail($sformatf("d%0d_req_accept", d));
        end
        req_valid[d] = 1'b0;
    endtask

    // Full transaction; hold > 0 keeps rsp_ready low for hold edges while a
    // stray request is offered, which must be ignored.
    task automatic do_txn(input int d, input bit wr, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er);
        bit ok;
        bit got;
        rd = 32'd0;
        er = 1'b0;
        rsp_ready[d] = (hold == 0);
        send_req(d, wr, a, wd, be, ok);
        if (!ok) return;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            timeout_fail($sformatf("d%0d_rsp_wait", d));
            return;
        end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        if (hold > 0) begin
            #1;
            req_valid[d] = 1'b1;
            req_write[d] = 1'b1;
            req_addr[d]  = 10'h004;
            req_wdata[d] = 32'hFFFF_FFFF;
            repeat (hold) @(posedge clk);
            #1;
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        bit          ok;
        logic [9:0]  a;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d]    = 4'hF; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-WAIT drops the pending store.
        send_req(0, 1'b1, 10'h020, 32'hCAFE_F00D, 4'hF, ok);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, 1'b0, 10'h020, 32'd0, 4'hF, 0, rd, er);
        check("reset_load_020", rd, 32'd0);
        do_txn(1, 1'b0, 10'h3FC, 32'd0, 4'hF, 0, rd, er);
        check("reset_load_3fc", rd, 32'd0);

        // Store then load back with two wait states.
        do_txn(0, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("store_010_rdata", rd, 32'd0);
        check("store_010_err", 32'(er), 32'd0);
        do_txn(0, 1'b0, 10'h010, 32'd0, 4'hF, 0, rd, er);
        check("load_010_rdata", rd, 32'hDEAD_BEEF);
        check("load_010_err", 32'(er), 32'd0);

        // Backpressure for 10 cycles.
        do_txn(0, 1'b1, 10'h024, 32'h0BAD_F00D, 4'hF, 10, rd, er);
        do_txn(0, 1'b0, 10'h024, 32'd0, 4'hF, 10, rd, er);
        check("bp_load_024", rd, 32'h0BAD_F00D);

        // Error cases on the 128-word instance.
        do_txn(0, 1'b0, 10'h013, 32'd0, 4'hF, 0, rd, er);
        check("misaligned_err", 32'(er), 32'd1);
        check("misaligned_rdata", rd, 32'd0);
        do_txn(0, 1'b1, 10'h000, 32'h1234_5678, 4'hF, 0, rd, er);
        do_txn(0, 1'b1, 10'h200, 32'h55AA_55AA, 4'hF, 0, rd, er);
        check("range_store_err", 32'(er), 32'd1);
        do_txn(0, 1'b0, 10'h000, 32'd0, 4'hF, 0, rd, er);
        check("after_range_load_000", rd, 32'h1234_5678);
        do_txn(0, 1'b0, 10'h1FC, 32'd0, 4'hF, 0, rd, er);
        check("last_word_err", 32'(er), 32'd0);

        // Zero wait states, back to back with rsp_ready held high.
        for (int i = 0; i < 8; i++)
            do_txn(1, 1'b1, 10'(4 * i), 32'h0101_0101 * (i + 3), 4'hF, 0, rd, er);
        for (int i = 0; i < 8; i++) begin
            do_txn(1, 1'b0, 10'(4 * i), 32'd0, 4'hF, 0, rd, er);
            check($sformatf("b2b_load_%0d", i), rd, 32'h0101_0101 * (i + 3));
        end

`ifdef MIPS_DMEM_BYTE_STROBE_EN
        do_txn(1, 1'b1, 10'h040, 32'h1122_3344, 4'hF, 0, rd, er);
        do_txn(1, 1'b1, 10'h040, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
        do_txn(1, 1'b1, 10'h040, 32'hFFFF_FFFF, 4'b0000, 0, rd, er);
        check("be0_store_err", 32'(er), 32'd0);
        do_txn(1, 1'b0, 10'h040, 32'd0, 4'b0000, 0, rd, er);
        check("be_load_040", rd, 32'h11BB_33DD);
`endif

        // Randomized traffic checked by the monitors.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(0, 1023));
                else                           a = {4'b0000, 4'($urandom_range(0, 15)), 2'b00};
                do_txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3), rd, er);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
